regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 110 +++++++++++
 tb/tb_regfile_writeback.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results win over a 2-deep load FIFO,
// with starvation relief for loads and same-cycle forwarding of the write.
module regfile_writeback #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aluValid,
  input  logic [4:0]  aluRd,
  input  logic [31:0] aluData,
  input  logic        memValid,
  input  logic [4:0]  memRd,
  input  logic [31:0] memData,
  output logic        memReady,
  output logic        aluStall,
  output logic        WE,
  output logic [4:0]  writePortSEL,
  output logic [31:0] writePort,
  input  logic [4:0]  readPort1SEL,
  input  logic [4:0]  readPort2SEL,
  output logic        fwd1Hit,
  output logic        fwd2Hit,
  output logic [31:0] fwd1Data,
  output logic [31:0] fwd2Data
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [4:0]  fifo_rd   [2];
  logic [31:0] fifo_data [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  logic        stall_q;
  logic        we_q;
  logic [4:0]  sel_q;
  logic [31:0] data_q;

  logic mem_ready;
  logic push;
  logic pop;
  logic alu_live;

  assign mem_ready = (count < 2'd2) && !rst;
  assign push      = memValid && mem_ready && (memRd != 5'd0);
  assign alu_live  = aluValid && (aluRd != 5'd0) && !stall_q;
  // Pop decision uses the pre-push count, so nothing falls through.
  assign pop       = !alu_live && (count != 2'd0);

  assign count_next = count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    starve_next = starve_cnt;
    if (pop || count == 2'd0) begin
      starve_next = 4'd0;
    end else if (alu_live && starve_cnt != LIM) begin
      starve_next = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= 4'd0;
      stall_q    <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 5'd0;
      data_q     <= 32'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count      <= count_next;
      starve_cnt <= starve_next;
      stall_q    <= (starve_next == LIM);
      we_q       <= alu_live || pop;
      if (alu_live) begin
        sel_q  <= aluRd;
        data_q <= aluData;
      end else if (pop) begin
        sel_q  <= fifo_rd[rd_ptr];
        data_q <= fifo_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= memRd;
      fifo_data[wr_ptr] <= memData;
    end
  end

  // Outputs read as idle for the whole time reset is held.
  assign memReady     = mem_ready;
  assign aluStall     = stall_q && !rst;
  assign WE           = we_q && !rst;
  assign writePortSEL = rst ? 5'd0 : sel_q;
  assign writePort    = rst ? 32'd0 : data_q;

  assign fwd1Hit  = WE && (writePortSEL == readPort1SEL) && (readPort1SEL != 5'd0);
  assign fwd2Hit  = WE && (writePortSEL == readPort2SEL) && (readPort2SEL != 5'd0);
  assign fwd1Data = writePort;
  assign fwd2Data = writePort;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_regfile_writeback;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        memValid;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        memReady;
  logic        aluStall;
  logic        WE;
  logic [4:0]  writePortSEL;
  logic [31:0] writePort;
  logic [4:0]  readPort1SEL;
  logic [4:0]  readPort2SEL;
  logic        fwd1Hit;
  logic        fwd2Hit;
  logic [31:0] fwd1Data;
  logic [31:0] fwd2Data;

  regfile_writeback #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData),
    .memValid(memValid), .memRd(memRd), .memData(memData),
    .memReady(memReady), .aluStall(aluStall),
    .WE(WE), .writePortSEL(writePortSEL), .writePort(writePort),
    .readPort1SEL(readPort1SEL), .readPort2SEL(readPort2SEL),
    .fwd1Hit(fwd1Hit), .fwd2Hit(fwd2Hit),
    .fwd1Data(fwd1Data), .fwd2Data(fwd2Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq [$];
  int          m_starve;
  bit          m_stall;
  bit          m_we;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  logic [4:0]  wlog [$];
  int          tests;
  int          fails;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Reference: FIFO as a queue, fixed priority, starvation as a plain count.
  task automatic model();
    int sz;
    bit ready;
    bit live;
    bit pop;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      m_stall  = 0;
      m_we     = 0;
      m_sel    = '0;
      m_data   = '0;
    end else begin
      sz    = mq.size();
      ready = sz < 2;
      live  = aluValid && aluRd != 0 && !m_stall;
      pop   = !live && sz > 0;
      if (live) begin
        m_we = 1; m_sel = aluRd; m_data = aluData;
      end else if (pop) begin
        m_we = 1; m_sel = mq[0].rd; m_data = mq[0].d;
      end else begin
        m_we = 0;
      end
      if (pop || sz == 0) m_starve = 0;
      else if (live && m_starve < LIMIT) m_starve++;
      if (pop) void'(mq.pop_front());
      if (memValid && ready && memRd != 0) mq.push_back('{memRd, memData});
      m_stall = (m_starve == LIMIT);
    end
  endtask

  task automatic compare();
    bit          e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
    e_we   = rst ? 1'b0 : m_we;
    e_sel  = rst ? 5'd0 : m_sel;
    e_data = rst ? 32'd0 : m_data;
    chk("WE", WE, e_we);
    chk("writePortSEL", writePortSEL, e_sel);
    chk("writePort", writePort, e_data);
    chk("memReady", memReady, !rst && mq.size() < 2);
    chk("aluStall", aluStall, rst ? 1'b0 : m_stall);
    chk("fwd1Hit", fwd1Hit, e_we && e_sel == readPort1SEL && readPort1SEL != 0);
    chk("fwd2Hit", fwd2Hit, e_we && e_sel == readPort2SEL && readPort2SEL != 0);
    chk("fwd1Data", fwd1Data, e_data);
    chk("fwd2Data", fwd2Data, e_data);
    if (WE) wlog.push_back(writePortSEL);
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    aluValid = 0; aluRd = 0; aluData = 0;
    memValid = 0; memRd = 0; memData = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic load_send(input logic [4:0] rd, input logic [31:0] d);
    bit acc;
    int n;
    n = 0;
    memValid = 1; memRd = rd; memData = d;
    do begin
      acc = mq.size() < 2;
      cyc();
      n++;
    end while (!acc && n < 50);
    chk("load_accept_timeout", acc, 1'b1);
    memValid = 0;
  endtask

  initial begin
    int n;
    int k;
    tests = 0;
    fails = 0;
    readPort1SEL = 0;
    readPort2SEL = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    compare();
    cyc();
    cyc();
    rst = 0;
    #1;
    chk("ready_after_rst", memReady, 1'b1);

    // ALU alone
    aluValid = 1; aluRd = 5; aluData = 32'hDEADBEEF;
    cyc();
    chk("alu_we", WE, 1'b1);
    chk("alu_sel", writePortSEL, 5'd5);
    chk("alu_data", writePort, 32'hDEADBEEF);
    idle_inputs();
    cyc();
    chk("alu_idle_we", WE, 1'b0);

    // x0 drop
    reset_dut();
    aluValid = 1; aluRd = 0; aluData = 32'h1;
    memValid = 1; memRd = 0; memData = 32'h2;
    wlog.delete();
    repeat (3) cyc();
    chk("x0_no_write", wlog.size(), 0);
    chk("x0_ready", memReady, 1'b1);

    // Full FIFO under constant ALU pressure
    reset_dut();
    wlog.delete();
    aluValid = 1; aluRd = 7; aluData = 32'h77;
    load_send(1, 32'h101);
    load_send(2, 32'h202);
    chk("full_not_ready", memReady, 1'b0);
    load_send(3, 32'h303);
    repeat (20) cyc();
    aluValid = 0;
    repeat (3) cyc();
    n = 0;
    k = 0;
    foreach (wlog[i]) begin
      if (wlog[i] != 7) begin
        if (n == 0) k = wlog[i];
        else k = k * 10 + wlog[i];
        n++;
      end
    end
    chk("load_count", n, 3);
    chk("load_order", k, 123);

    // Starvation relief
    reset_dut();
    load_send(4, 32'h444);
    aluValid = 1; aluRd = 8; aluData = 32'h888;
    repeat (3) cyc();
    chk("stall_before", aluStall, 1'b0);
    cyc();
    chk("stall_after_4", aluStall, 1'b1);
    cyc();
    chk("starve_load_we", WE, 1'b1);
    chk("starve_load_sel", writePortSEL, 5'd4);
    chk("stall_release", aluStall, 1'b0);

    // Forwarding
    reset_dut();
    aluValid = 1; aluRd = 9; aluData = 32'h12345678;
    readPort1SEL = 9; readPort2SEL = 9;
    cyc();
    chk("fwd_both1", fwd1Hit, 1'b1);
    chk("fwd_both2", fwd2Hit, 1'b1);
    chk("fwd_data1", fwd1Data, 32'h12345678);
    chk("fwd_data2", fwd2Data, 32'h12345678);
    readPort1SEL = 0;
    #1;
    chk("fwd_x0", fwd1Hit, 1'b0);
    chk("fwd_other", fwd2Hit, 1'b1);
    idle_inputs();
    cyc();

    // Reset with a full FIFO
    reset_dut();
    aluValid = 1; aluRd = 7; aluData = 32'h7;
    load_send(11, 32'hB);
    load_send(12, 32'hC);
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("midrst_ready", memReady, 1'b1);
    wlog.delete();
    repeat (5) cyc();
    n = 0;
    foreach (wlog[i]) if (wlog[i] == 11 || wlog[i] == 12) n++;
    chk("midrst_no_write", n, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      aluValid     = ($urandom_range(0, 9) < 6);
      aluRd        = 5'($urandom_range(0, 31));
      aluData      = $urandom;
      memValid     = ($urandom_range(0, 1) == 1);
      memRd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      memData      = $urandom;
      readPort1SEL = 5'($urandom_range(0, 31));
      readPort2SEL = ($urandom_range(0, 3) == 0) ? readPort1SEL : 5'($urandom_range(0, 31));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
